riscv_instr_encoder: RTL and testbench
======================================

RISCV_INSTR_ENCODER -- requirements
Module: riscv_instr_encoder

Interface
REQ-001 Parameters: ADDR_W, 32, output address width; RESET_ADDR, 0, address loaded on reset.
REQ-002 Ports: clk  in  1  rising-edge clock; rst_n  in  1  reset, asynchronous and active-low.
REQ-003 in_valid  in  1  field bundle valid; in_ready  out  1  encoder can accept.
REQ-004 fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-005 opcode  in  7; funct3  in  3; funct7  in  7; rd, rs1, rs2  in  5 each; imm  in  32  signed (U: value of bits 31:12).
REQ-006 base_load  in  1  pulse; base_addr  in  ADDR_W  new write address.
REQ-007 out_valid  out  1; out_ready  in  1; out_instr  out  32  encoded word; out_addr  out  ADDR_W  byte address of word.
REQ-008 err  out  1  sticky illegal-input flag; err_clr  in  1  clears err.

Function
REQ-009 Handshake: transfer on the same edge where valid and ready are both high; in_ready high whenever buffer holds fewer than 2 entries, independent of in_valid.
REQ-010 Buffer: 2-entry FIFO; states EMPTY, ONE, FULL; accept-only increments, pop-only decrements, simultaneous accept and pop holds the state.
REQ-011 Latency: accepted bundle appears on out_instr/out_valid the cycle after acceptance when buffer was EMPTY; FIFO order always preserved.
REQ-012 out_instr, out_valid, out_addr stable while out_valid high and out_ready low.
REQ-013 R: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-014 I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-015 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-016 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-017 U: {imm[19:0], rd, opcode}.
REQ-018 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-019 Address counter: each accepted, non-dropped bundle is tagged with current counter, then counter += 4; wraps modulo 2^ADDR_W.
REQ-020 base_load loads counter next edge; if coincident with an accept, accepted word gets base_addr and counter becomes base_addr+4.
REQ-021 Illegal fmt (6, 7): bundle accepted, dropped (not buffered, counter unchanged), err set.
REQ-022 err set has priority over err_clr in the same cycle.

Reset
REQ-023 rst_n low asynchronously: buffer EMPTY, out_valid 0, out_instr 0, out_addr RESET_ADDR, counter RESET_ADDR, err 0; in_ready 1.
REQ-024 Reset mid-transfer discards all buffered words; no partial output after release.
REQ-025 First accept possible on first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro ENC_RANGE_CHECK_EN defined: I/S imm outside [-2048, 2047], B imm outside [-4096, 4094] or odd, J imm outside [-2^20, 2^20-2] or odd, U imm outside [0, 2^20-1] -> bundle dropped per REQ-021, err set.
REQ-027 Macro undefined: no range check; imm bits truncated per REQ-014..018; err driven only by illegal fmt.

Verification
REQ-028 Reset, fmt=R, opcode=0110011, funct3=0, funct7=0, rd=3, rs1=1, rs2=2, out_ready=1 -> next cycle out_instr=0x002081B3, out_addr=0x0.
REQ-029 fmt=I, opcode=0010011, rd=5, rs1=0, imm=-1 then fmt=J, opcode=1101111, rd=1, imm=8 -> 0xFFF00293 @0x0, 0x008000EF @0x4.
REQ-030 out_ready=0, three back-to-back bundles -> in_ready low after two accepts; third accepted only after one pop; order preserved.
REQ-031 base_load=1, base_addr=0x100 with accepted B beq x1,x2,imm=-4 -> out_addr=0x100, out_instr=0xFE208EE3; next word at 0x104.
REQ-032 fmt=7 -> err=1, no output, counter unchanged; with ENC_RANGE_CHECK_EN, fmt=I imm=4096 -> err=1, dropped; err_clr -> err=0.
REQ-033 rst_n low while FULL -> out_valid 0 immediately, counter RESET_ADDR.

Source files
------------

// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder: packs RISC-V instruction fields (R/I/S/B/U/J) into
// 32-bit words, tags each with a running byte address and queues them in a
// 2-entry FIFO behind a valid/ready handshake.
// Optional feature: define ENC_RANGE_CHECK_EN to drop bundles whose immediate
// does not fit the selected format (the bundle is then treated as illegal).
module riscv_instr_encoder #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    fifo_state_t       state;
    fifo_state_t       next_state;
    logic [31:0]       instr_mem [2];
    logic [ADDR_W-1:0] addr_mem  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] tag_addr;
    logic [31:0]       enc_word;
    logic              fmt_legal;
    logic              imm_legal;
    logic              accept;
    logic              push;
    logic              pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_instr = instr_mem[rd_ptr];
    assign out_addr  = addr_mem[rd_ptr];

    assign fmt_legal = (fmt <= 3'd5);
    assign accept    = in_valid && in_ready;
    assign push      = accept && fmt_legal && imm_legal;
    assign pop       = out_valid && out_ready;

    // A coincident base_load retargets the word being accepted this cycle
    assign tag_addr  = base_load ? base_addr : counter;

`ifdef ENC_RANGE_CHECK_EN
    logic signed [31:0] s_imm;
    assign s_imm = imm;

    // Immediate must be representable in the chosen format (and even for B/J)
    always_comb begin
        imm_legal = 1'b1;
        case (fmt)
            3'd1, 3'd2: imm_legal = (s_imm >= -2048) && (s_imm <= 2047);
            3'd3:       imm_legal = (s_imm >= -4096) && (s_imm <= 4094) && !imm[0];
            3'd4:       imm_legal = (s_imm >= 0) && (s_imm <= 1048575);
            3'd5:       imm_legal = (s_imm >= -1048576) && (s_imm <= 1048574) && !imm[0];
            default:    imm_legal = 1'b1;
        endcase
    end
`else
    // Without range checking the upper and lowest immediate bits are simply truncated
    logic unused_imm_bits;
    assign unused_imm_bits = ^{imm[31:21], imm[0]};
    assign imm_legal       = 1'b1;
`endif

    // Field packing for each instruction format
    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            3'd4: enc_word = {imm[19:0], rd, opcode};
            3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_word = 32'h0;
        endcase
    end

    // FIFO occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= next_state;
    end

    // Occupancy moves up on push-only, down on pop-only, holds otherwise
    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (push) next_state = ONE;
            ONE:     if (push && !pop) next_state = FULL;
                     else if (!push && pop) next_state = EMPTY;
            FULL:    if (pop) next_state = ONE;
            default: next_state = EMPTY;
        endcase
    end

    // FIFO storage and pointers; reset clears so out_instr/out_addr read idle values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_mem[0] <= 32'h0;
            instr_mem[1] <= 32'h0;
            addr_mem[0]  <= RESET_ADDR;
            addr_mem[1]  <= RESET_ADDR;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= enc_word;
                addr_mem[wr_ptr]  <= tag_addr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    // Address counter advances only for buffered words; base_load retargets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         counter <= RESET_ADDR;
        else if (push)      counter <= tag_addr + ADDR_STEP;
        else if (base_load) counter <= base_addr;
    end

    // Sticky error: a dropped bundle sets it and wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err <= 1'b0;
        else if (accept && !push)   err <= 1'b1;
        else if (err_clr)           err <= 1'b0;
    end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// tb_riscv_instr_encoder: directed vector table for the encoder plus hand
// sequences for backpressure, base_load, illegal bundles and reset while full.
module tb_riscv_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [31:0] imm = 32'd0;
    logic        base_load = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic        err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [9];

    riscv_instr_encoder #(.ADDR_W(32), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .base_load(base_load), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_clr(err_clr)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addBundle(input logic [4:0] d);
        applyStimulus(3'd0, 7'b0110011, 3'd0, 7'd0, d, 5'd1, 5'd2, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"r_add",    3'd0, 7'b0110011, 3'd0, 7'b0000000, 5'd3,  5'd1, 5'd2, 32'd0,         32'h002081B3};
        vecs[1] = '{"i_neg1",   3'd1, 7'b0010011, 3'd0, 7'd0,       5'd5,  5'd0, 5'd0, 32'hFFFFFFFF,  32'hFFF00293};
        vecs[2] = '{"j_pos8",   3'd5, 7'b1101111, 3'd0, 7'd0,       5'd1,  5'd0, 5'd0, 32'd8,         32'h008000EF};
        vecs[3] = '{"s_sw",     3'd2, 7'b0100011, 3'd2, 7'd0,       5'd0,  5'd1, 5'd2, 32'd8,         32'h0020A423};
        vecs[4] = '{"u_lui",    3'd4, 7'b0110111, 3'd0, 7'd0,       5'd10, 5'd0, 5'd0, 32'h00012345,  32'h12345537};
        vecs[5] = '{"r_sub",    3'd0, 7'b0110011, 3'd0, 7'b0100000, 5'd3,  5'd1, 5'd2, 32'd0,         32'h402081B3};
        vecs[6] = '{"b_pos16",  3'd3, 7'b1100011, 3'd0, 7'd0,       5'd0,  5'd1, 5'd2, 32'd16,        32'h00208863};
        vecs[7] = '{"i_min",    3'd1, 7'b0010011, 3'd0, 7'd0,       5'd1,  5'd1, 5'd0, 32'hFFFFF800,  32'h80008093};
        vecs[8] = '{"j_neg4",   3'd5, 7'b1101111, 3'd0, 7'd0,       5'd0,  5'd0, 5'd0, 32'hFFFFFFFC,  32'hFFDFF06F};

        // Reset values
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_err",       32'(err),       32'd0);
        checkOutput("rst_out_instr", out_instr,      32'd0);
        checkOutput("rst_out_addr",  out_addr,       32'd0);
        tick();
        rst_n = 1'b1;

        // Table: one bundle per cycle with out_ready high, expect 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].fmt, vecs[i].opcode, vecs[i].funct3, vecs[i].funct7,
                          vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            tick();
            checkOutput({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({vecs[i].name, "_instr"}, out_instr, vecs[i].exp_instr);
            checkOutput({vecs[i].name, "_addr"},  out_addr,  32'(4 * i));
        end
        in_valid = 1'b0;
        tick();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: fill, stall third bundle, release one, then third enters
        out_ready = 1'b0;
        addBundle(5'd3);
        tick();
        checkOutput("bp_a_instr", out_instr, 32'h002081B3);
        checkOutput("bp_a_ready", 32'(in_ready), 32'd1);
        addBundle(5'd4);
        tick();
        checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
        addBundle(5'd5);
        tick();
        checkOutput("bp_stall_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_stall_instr", out_instr, 32'h002081B3);
        checkOutput("bp_stall_addr",  out_addr,  32'h24);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_b_instr", out_instr, 32'h00208233);
        checkOutput("bp_b_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checkOutput("bp_b_hold_addr", out_addr, 32'h28);
        checkOutput("bp_full_again", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_c_instr", out_instr, 32'h002082B3);
        checkOutput("bp_c_addr",  out_addr,  32'h2C);
        tick();
        checkOutput("bp_empty", 32'(out_valid), 32'd0);

        // base_load coincident with an accept, then base_load alone
        applyStimulus(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        base_load = 1'b1;
        base_addr = 32'h100;
        tick();
        base_load = 1'b0;
        checkOutput("bl_beq_instr", out_instr, 32'hFE208EE3);
        checkOutput("bl_beq_addr",  out_addr,  32'h100);
        addBundle(5'd3);
        tick();
        checkOutput("bl_next_addr", out_addr, 32'h104);
        in_valid  = 1'b0;
        base_load = 1'b1;
        base_addr = 32'h200;
        tick();
        base_load = 1'b0;
        addBundle(5'd4);
        tick();
        checkOutput("bl_alone_addr",  out_addr,  32'h200);
        checkOutput("bl_alone_instr", out_instr, 32'h00208233);

        // Illegal format: dropped, counter untouched, err sticky and wins over clear
        applyStimulus(3'd7, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        checkOutput("ill_err",   32'(err),       32'd1);
        checkOutput("ill_valid", 32'(out_valid), 32'd0);
        addBundle(5'd5);
        tick();
        checkOutput("ill_next_addr", out_addr, 32'h204);
        checkOutput("ill_err_sticky", 32'(err), 32'd1);
        applyStimulus(3'd6, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        err_clr = 1'b1;
        tick();
        checkOutput("ill_set_over_clr", 32'(err), 32'd1);
        checkOutput("ill6_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        checkOutput("err_cleared", 32'(err), 32'd0);

        // Out-of-range I immediate: dropped with range check, truncated without
        applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd4096);
        tick();
        in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        checkOutput("rc_err",   32'(err),       32'd1);
        checkOutput("rc_valid", 32'(out_valid), 32'd0);
`else
        checkOutput("trunc_err",   32'(err), 32'd0);
        checkOutput("trunc_instr", out_instr, 32'h00000293);
        checkOutput("trunc_addr",  out_addr,  32'h208);
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("rc_err_cleared", 32'(err), 32'd0);

        // Reset while FULL: outputs clear immediately, counter back to RESET_ADDR
        out_ready = 1'b0;
        addBundle(5'd3);
        tick();
        addBundle(5'd4);
        tick();
        in_valid = 1'b0;
        checkOutput("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready),  32'd1);
        checkOutput("mid_rst_instr", out_instr,      32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        addBundle(5'd5);
        tick();
        in_valid = 1'b0;
        checkOutput("post_rst_instr", out_instr, 32'h002082B3);
        checkOutput("post_rst_addr",  out_addr,  32'h0);
        tick();
        checkOutput("post_rst_empty", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
